// File: rtl/leitor_display.sv
// leitor_display
// Observes the multiplexed 4-digit seven-segment bus (d1..d4, a..g, ponto),
// decodes each digit window back to a hex value, debounces it over several
// scans and publishes the reconstructed display with status flags.
//
// Parameters:
//   ESTAVEL     identical consecutive decodes needed to commit a digit (1..15)
//   TIMEOUT     cycles without a completed window before the scan is stopped
//   ATIVO_BAIXO 1: bus lines are active-low, 0: active-high
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   d1..d4             digit enables (d1 = digit 0, most significant)
//   a..g, ponto        segment lines and decimal point
//   valor[15:0]        committed values, digit 0 in [15:12]
//   pontos[3:0]        committed decimal points, bit 3 = digit 0
//   branco[3:0]        committed blank flags, bit 3 = digit 0
//   valido             every digit committed since reset/timeout
//   novo               pulse when a committed digit changes
//   erro_padrao        pulse when a window ends on an undecodable pattern
//   erro_conflito      pulse for every cycle with 2+ enables active
//   sem_varredura      scan stopped (timeout)
module leitor_display #(
    parameter int unsigned ESTAVEL     = 3,
    parameter int unsigned TIMEOUT     = 50000,
    parameter bit          ATIVO_BAIXO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d1,
    input  logic        d2,
    input  logic        d3,
    input  logic        d4,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        ponto,
    output logic [15:0] valor,
    output logic [3:0]  pontos,
    output logic [3:0]  branco,
    output logic        valido,
    output logic        novo,
    output logic        erro_padrao,
    output logic        erro_conflito,
    output logic        sem_varredura
);

    localparam int unsigned IW_MIN = $clog2(TIMEOUT + 1);
    localparam int unsigned IW     = (IW_MIN > 17) ? IW_MIN : 17;
    localparam logic [IW-1:0] TMO      = IW'(TIMEOUT);
    localparam logic [IW-1:0] TMO_LAST = IW'(TIMEOUT - 1);
    localparam logic [3:0]    EST      = 4'(ESTAVEL);

    // Input stage; the normalised (active-high) copy is what gets stored so
    // that the cleared register means "nothing active" for either polarity.
    logic [3:0]    r_en;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          r_open;
    logic [1:0]    r_cur;
    logic [6:0]    r_pat;
    logic          r_pdp;
    logic [IW-1:0] r_idle;

    logic [3:0]    r_cval [4];
    logic          r_cblk [4];
    logic          r_cdp  [4];
    logic [3:0]    r_cnt  [4];
    logic [3:0]    r_kval [4];
    logic          r_kblk [4];
    logic          r_kdp  [4];
    logic [3:0]    r_seen;

    logic          r_novo;
    logic          r_epad;
    logic          r_econf;
    logic          r_sem;

    logic          w_conf;
    logic          w_one;
    logic [1:0]    w_idx;
    logic [3:0]    w_mask;
    logic          w_end;
    logic          w_dok;
    logic          w_dblk;
    logic [3:0]    w_dval;
    logic          w_eval;
    logic          w_same;
    logic [3:0]    w_ncnt;
    logic          w_differs;
    logic          w_commit;
    logic          w_tmo;

    always_comb begin
        w_conf = (r_en & (r_en - 4'd1)) != 4'd0;
        w_one  = (r_en != 4'd0) && !w_conf;
        w_idx  = 2'd0;
        case (r_en)
            4'b0100: w_idx = 2'd1;
            4'b0010: w_idx = 2'd2;
            4'b0001: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
        w_mask = 4'b1000 >> r_cur;
        // A conflict cycle aborts the window instead of ending it.
        w_end  = r_open && !w_conf && (r_en != w_mask);

        w_dok  = 1'b1;
        w_dblk = 1'b0;
        w_dval = 4'h0;
        case (r_pat)
            7'b1111110: w_dval = 4'h0;
            7'b0110000: w_dval = 4'h1;
            7'b1101101: w_dval = 4'h2;
            7'b1111001: w_dval = 4'h3;
            7'b0110011: w_dval = 4'h4;
            7'b1011011: w_dval = 4'h5;
            7'b1011111: w_dval = 4'h6;
            7'b1110000: w_dval = 4'h7;
            7'b1111111: w_dval = 4'h8;
            7'b1111011: w_dval = 4'h9;
            7'b1110111: w_dval = 4'hA;
            7'b0011111: w_dval = 4'hB;
            7'b1001110: w_dval = 4'hC;
            7'b0111101: w_dval = 4'hD;
            7'b1001111: w_dval = 4'hE;
            7'b1000111: w_dval = 4'hF;
            7'b0000000: w_dblk = 1'b1;
            default:    w_dok  = 1'b0;
        endcase

        w_eval = w_end && w_dok;
        w_same = (r_cval[r_cur] == w_dval) && (r_cblk[r_cur] == w_dblk) &&
                 (r_cdp[r_cur] == r_pdp);
        if (!w_same)
            w_ncnt = 4'd1;
        else if (r_cnt[r_cur] >= EST)
            w_ncnt = EST;
        else
            w_ncnt = r_cnt[r_cur] + 4'd1;
        // New candidate always equals the decode, so compare the decode directly.
        w_differs = (r_kval[r_cur] != w_dval) || (r_kblk[r_cur] != w_dblk) ||
                    (r_kdp[r_cur] != r_pdp);
        // An unchanged commit still matters: it marks the digit as seen.
        w_commit  = w_eval && (w_ncnt == EST) && (w_differs || !r_seen[r_cur]);
        w_tmo     = !w_end && (r_idle == TMO_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en    <= '0;
            r_seg   <= '0;
            r_dp    <= 1'b0;
            r_open  <= 1'b0;
            r_cur   <= '0;
            r_pat   <= '0;
            r_pdp   <= 1'b0;
            r_idle  <= '0;
            r_seen  <= '0;
            r_novo  <= 1'b0;
            r_epad  <= 1'b0;
            r_econf <= 1'b0;
            r_sem   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cval[i] <= '0;
                r_cblk[i] <= 1'b0;
                r_cdp[i]  <= 1'b0;
                r_cnt[i]  <= '0;
                r_kval[i] <= '0;
                r_kblk[i] <= 1'b0;
                r_kdp[i]  <= 1'b0;
            end
        end else begin
            r_en    <= {d1, d2, d3, d4} ^ {4{ATIVO_BAIXO}};
            r_seg   <= {a, b, c, d, e, f, g} ^ {7{ATIVO_BAIXO}};
            r_dp    <= ponto ^ ATIVO_BAIXO;

            r_novo  <= 1'b0;
            r_epad  <= w_end && !w_dok;
            r_econf <= w_conf;

            if (w_conf) begin
                r_open <= 1'b0;
            end else if (w_one) begin
                r_open <= 1'b1;
                r_cur  <= w_idx;
                r_pat  <= r_seg;
                r_pdp  <= r_dp;
            end else begin
                r_open <= 1'b0;
            end

            if (w_end)
                r_idle <= '0;
            else if (r_idle != TMO)
                r_idle <= r_idle + 1'b1;

            if (w_eval) begin
                r_cval[r_cur] <= w_dval;
                r_cblk[r_cur] <= w_dblk;
                r_cdp[r_cur]  <= r_pdp;
                r_cnt[r_cur]  <= w_ncnt;
            end

            if (w_commit) begin
                r_kval[r_cur] <= w_dval;
                r_kblk[r_cur] <= w_dblk;
                r_kdp[r_cur]  <= r_pdp;
                r_seen[r_cur] <= 1'b1;
                r_novo        <= w_differs;
            end

            // w_tmo already excludes a window end, so the two never collide.
            if (w_end) begin
                r_sem <= 1'b0;
            end else if (w_tmo) begin
                r_sem  <= 1'b1;
                r_seen <= '0;
                for (int unsigned i = 0; i < 4; i++)
                    r_cnt[i] <= '0;
            end
        end
    end

    assign valor         = {r_kval[0], r_kval[1], r_kval[2], r_kval[3]};
    assign pontos        = {r_kdp[0], r_kdp[1], r_kdp[2], r_kdp[3]};
    assign branco        = {r_kblk[0], r_kblk[1], r_kblk[2], r_kblk[3]};
    assign valido        = &r_seen;
    assign novo          = r_novo;
    assign erro_padrao   = r_epad;
    assign erro_conflito = r_econf;
    assign sem_varredura = r_sem;

endmodule
